// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller uses the master modport; the datapath (or a bench standing in for it) uses slave.
interface multicycle_controller_if;
    logic [19:0] instruction;
    logic [3:0]  alu_flags;
    logic        pc_write;
    logic        ir_write;
    logic        address_source;
    logic        alu_source_a;
    logic        register_write;
    logic        memory_write;
    logic        instruction_done;
    logic [1:0]  result_source;
    logic [1:0]  alu_source_b;
    logic [1:0]  alu_control;
    logic [1:0]  immediate_source;
    logic [1:0]  register_source;
    logic [3:0]  state;

    modport master (
        input  instruction, alu_flags,
        output pc_write, ir_write, address_source, alu_source_a, register_write,
               memory_write, instruction_done, result_source, alu_source_b,
               alu_control, immediate_source, register_source, state
    );

    modport slave (
        output instruction, alu_flags,
        input  pc_write, ir_write, address_source, alu_source_a, register_write,
               memory_write, instruction_done, result_source, alu_source_b,
               alu_control, immediate_source, register_source, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore controller for a multicycle ARM-subset datapath (LDR/STR, data processing, B).
// State encoding on the debug port follows the listing order: FETCH=0 ... BRANCH=9.
module multicycle_controller (
    input  logic                           clock,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      r_state;
    logic [3:0]  r_flags;
    logic        r_cond_q;
    logic        r_pc_write;
    logic        r_ir_write;
    logic        r_address_source;
    logic        r_alu_source_a;
    logic        r_register_write;
    logic        r_memory_write;
    logic        r_done;
    logic [1:0]  r_result_source;
    logic [1:0]  r_alu_source_b;
    logic [1:0]  r_alu_control;

    state_t      w_next_state;
    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic [3:0]  w_rd;
    logic        w_unused_rn;
    logic [1:0]  w_dp_ctl;
    logic        w_cond_ex;
    logic        w_cond_next;
    logic        w_alu_wb_write;
    logic        w_flag_update;
    logic        w_n, w_z, w_c, w_v;

    assign w_cond      = bus.instruction[19:16];
    assign w_op        = bus.instruction[15:14];
    assign w_funct     = bus.instruction[13:8];
    assign w_rd        = bus.instruction[3:0];
    assign w_unused_rn = ^bus.instruction[7:4];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // ALU operation for data-processing instructions, from funct[4:1]
    always_comb begin
        w_dp_ctl = 2'b00;
        case (w_funct[4:1])
            4'b0100: w_dp_ctl = 2'b00;
            4'b0010: w_dp_ctl = 2'b01;
            4'b1010: w_dp_ctl = 2'b01;
            4'b0000: w_dp_ctl = 2'b10;
            4'b1100: w_dp_ctl = 2'b11;
            default: w_dp_ctl = 2'b00;
        endcase
    end

    // ARM condition check against the stored flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'h0: w_cond_ex = w_z;
            4'h1: w_cond_ex = ~w_z;
            4'h2: w_cond_ex = w_c;
            4'h3: w_cond_ex = ~w_c;
            4'h4: w_cond_ex = w_n;
            4'h5: w_cond_ex = ~w_n;
            4'h6: w_cond_ex = w_v;
            4'h7: w_cond_ex = ~w_v;
            4'h8: w_cond_ex = w_c & ~w_z;
            4'h9: w_cond_ex = ~w_c | w_z;
            4'hA: w_cond_ex = (w_n == w_v);
            4'hB: w_cond_ex = (w_n != w_v);
            4'hC: w_cond_ex = ~w_z & (w_n == w_v);
            4'hD: w_cond_ex = w_z | (w_n != w_v);
            4'hE: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Next-state selection plus the terms needed to pre-compute registered outputs
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b01:   w_next_state = S_MEMADR;
                    2'b00:   w_next_state = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
        // cond_q is loaded on the DECODE edge, so outputs entered from DECODE use the fresh value
        w_cond_next    = (r_state == S_DECODE) ? w_cond_ex : r_cond_q;
        w_alu_wb_write = w_cond_next & (w_funct[4:3] != 2'b10);
        w_flag_update  = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) &&
                         (w_op == 2'b00) && w_funct[0] && r_cond_q;
    end

    // State, flags, cond_q and registered outputs (decoded from the state being entered)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= S_FETCH;
            r_flags          <= '0;
            r_cond_q         <= 1'b0;
            r_pc_write       <= 1'b1;
            r_ir_write       <= 1'b1;
            r_address_source <= 1'b0;
            r_alu_source_a   <= 1'b1;
            r_register_write <= 1'b0;
            r_memory_write   <= 1'b0;
            r_done           <= 1'b0;
            r_result_source  <= 2'b10;
            r_alu_source_b   <= 2'b10;
            r_alu_control    <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_cond_q <= w_cond_ex;
            end
            if (w_flag_update) begin
                r_flags[3:2] <= bus.alu_flags[3:2];
                if (!w_dp_ctl[1]) begin
                    r_flags[1:0] <= bus.alu_flags[1:0];
                end
            end

            r_pc_write       <= 1'b0;
            r_ir_write       <= 1'b0;
            r_address_source <= 1'b0;
            r_alu_source_a   <= 1'b0;
            r_register_write <= 1'b0;
            r_memory_write   <= 1'b0;
            r_done           <= 1'b0;
            r_result_source  <= 2'b00;
            r_alu_source_b   <= 2'b00;
            r_alu_control    <= 2'b00;
            case (w_next_state)
                S_FETCH: begin
                    r_ir_write      <= 1'b1;
                    r_pc_write      <= 1'b1;
                    r_alu_source_a  <= 1'b1;
                    r_alu_source_b  <= 2'b10;
                    r_result_source <= 2'b10;
                end
                S_DECODE: begin
                    r_alu_source_a  <= 1'b1;
                    r_alu_source_b  <= 2'b10;
                    r_result_source <= 2'b10;
                end
                S_MEMADR: begin
                    r_alu_source_b <= 2'b01;
                end
                S_MEMREAD: begin
                    r_address_source <= 1'b1;
                end
                S_MEMWB: begin
                    r_result_source  <= 2'b01;
                    r_register_write <= w_cond_next;
                    r_pc_write       <= w_cond_next & (w_rd == 4'hF);
                    r_done           <= 1'b1;
                end
                S_MEMWRITE: begin
                    r_address_source <= 1'b1;
                    r_memory_write   <= w_cond_next;
                    r_done           <= 1'b1;
                end
                S_EXECUTER: begin
                    r_alu_control <= w_dp_ctl;
                end
                S_EXECUTEI: begin
                    r_alu_source_b <= 2'b01;
                    r_alu_control  <= w_dp_ctl;
                end
                S_ALUWB: begin
                    r_register_write <= w_alu_wb_write;
                    r_pc_write       <= w_alu_wb_write & (w_rd == 4'hF);
                    r_done           <= 1'b1;
                end
                S_BRANCH: begin
                    r_alu_source_b  <= 2'b01;
                    r_result_source <= 2'b10;
                    r_pc_write      <= w_cond_next;
                    r_done          <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Write strobes are gated by reset so an asserted reset kills them in the same cycle;
    // the undefined-op completion in DECODE depends on the freshly loaded instruction, so it stays combinational.
    assign bus.pc_write         = reset & r_pc_write;
    assign bus.ir_write         = reset & r_ir_write;
    assign bus.register_write   = reset & r_register_write;
    assign bus.memory_write     = reset & r_memory_write;
    assign bus.instruction_done = reset & (r_done | ((r_state == S_DECODE) && (w_op == 2'b11)));
    assign bus.address_source   = r_address_source;
    assign bus.alu_source_a     = r_alu_source_a;
    assign bus.result_source    = r_result_source;
    assign bus.alu_source_b     = r_alu_source_b;
    assign bus.alu_control      = r_alu_control;
    assign bus.immediate_source = w_op;
    assign bus.register_source  = {w_op == 2'b01, w_op == 2'b10};
    assign bus.state            = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequence, a reset abort, then random instructions
// checked against a per-instruction reference model of paths, outputs and flags.
module tb_multicycle_controller;

    // Debug encoding of the state port, in listing order
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4,
                   ST_MEMWRITE = 5, ST_EXECUTER = 6, ST_EXECUTEI = 7, ST_ALUWB = 8, ST_BRANCH = 9;

    typedef struct packed {
        logic       pcw, irw, asrc, asa, rw, mw, done;
        logic [1:0] rs, asb, actl, isrc, rsrc;
    } obs_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] mflags;
    logic [19:0] cur_ins;
    obs_t w_obs;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign w_obs = '{pcw: bus.pc_write, irw: bus.ir_write, asrc: bus.address_source,
                     asa: bus.alu_source_a, rw: bus.register_write, mw: bus.memory_write,
                     done: bus.instruction_done, rs: bus.result_source, asb: bus.alu_source_b,
                     actl: bus.alu_control, isrc: bus.immediate_source, rsrc: bus.register_source};

    function automatic logic [1:0] dp_of(input logic [5:0] f);
        case (f[4:1])
            4'b0100: return 2'd0;
            4'b0010: return 2'd1;
            4'b1010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic cond_of(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs for a state, straight from the per-state output table
    function automatic obs_t exp_obs(input int st, input logic [19:0] ins, input logic cq);
        obs_t e;
        logic [1:0] op;
        logic [5:0] fn;
        op = ins[15:14];
        fn = ins[13:8];
        e = '0;
        e.isrc = op;
        e.rsrc = {op == 2'd1, op == 2'd2};
        case (st)
            ST_FETCH:    begin e.irw = 1; e.pcw = 1; e.asa = 1; e.asb = 2; e.rs = 2; end
            ST_DECODE:   begin e.asa = 1; e.asb = 2; e.rs = 2; e.done = (op == 2'd3); end
            ST_MEMADR:   begin e.asb = 1; end
            ST_MEMREAD:  begin e.asrc = 1; end
            ST_MEMWB:    begin e.rs = 1; e.rw = cq; e.pcw = cq && ins[3:0] == 4'hF; e.done = 1; end
            ST_MEMWRITE: begin e.asrc = 1; e.mw = cq; e.done = 1; end
            ST_EXECUTER: begin e.actl = dp_of(fn); end
            ST_EXECUTEI: begin e.asb = 1; e.actl = dp_of(fn); end
            ST_ALUWB: begin
                e.rw = cq && (fn[4:3] != 2'b10);
                e.pcw = e.rw && ins[3:0] == 4'hF;
                e.done = 1;
            end
            ST_BRANCH:   begin e.asb = 1; e.rs = 2; e.pcw = cq; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_cycle(input string tag, input int st, input obs_t e);
        checks++;
        assert (bus.state === 4'(st)) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, bus.state, st);
        end
        checks++;
        assert (w_obs === e) else begin
            errors++;
            $error("FAIL %s outputs: got %h expected %h", tag, w_obs, e);
        end
    endtask

    // Runs one instruction starting just after an edge that left the DUT in FETCH
    task automatic run_instr(input logic [19:0] ins, input bit fix, input logic [3:0] fv);
        int path[$];
        logic cq;
        logic [1:0] op;
        logic [5:0] fn;
        op = ins[15:14];
        fn = ins[13:8];
        @(negedge clock);
        check_cycle("fetch", ST_FETCH, exp_obs(ST_FETCH, cur_ins, 1'b0));
        @(posedge clock); #1;
        cur_ins = ins;
        bus.instruction = ins;
        bus.alu_flags = fix ? fv : 4'($urandom);
        cq = cond_of(ins[19:16], mflags);
        case (op)
            2'd1: begin
                path.push_back(ST_MEMADR);
                if (fn[0]) begin path.push_back(ST_MEMREAD); path.push_back(ST_MEMWB); end
                else path.push_back(ST_MEMWRITE);
            end
            2'd0: begin
                path.push_back(fn[5] ? ST_EXECUTEI : ST_EXECUTER);
                path.push_back(ST_ALUWB);
            end
            2'd2: path.push_back(ST_BRANCH);
            default: ;
        endcase
        @(negedge clock);
        check_cycle("decode", ST_DECODE, exp_obs(ST_DECODE, ins, cq));
        foreach (path[k]) begin
            @(posedge clock); #1;
            bus.alu_flags = fix ? fv : 4'($urandom);
            @(negedge clock);
            check_cycle($sformatf("ins %h st %0d", ins, path[k]), path[k], exp_obs(path[k], ins, cq));
            if ((path[k] == ST_EXECUTER || path[k] == ST_EXECUTEI) && op == 2'd0 && fn[0] && cq) begin
                mflags[3:2] = bus.alu_flags[3:2];
                if (dp_of(fn) <= 2'd1) mflags[1:0] = bus.alu_flags[1:0];
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        obs_t e;
        checks = 0;
        errors = 0;
        mflags = '0;
        cur_ins = '0;
        reset = 1'b0;
        bus.instruction = '0;
        bus.alu_flags = '0;

        #12;
        e = exp_obs(ST_FETCH, cur_ins, 1'b0);
        e.irw = 0;
        e.pcw = 0;
        check_cycle("reset", ST_FETCH, e);
        @(posedge clock); #1;
        reset = 1'b1;

        run_instr(20'hE0821, 1, 4'b0000);
        run_instr(20'hE5921, 1, 4'b0000);
        run_instr(20'hE5821, 1, 4'b0000);
        run_instr(20'hE0500, 1, 4'b0100);
        run_instr(20'h0A000, 0, 4'b0000);
        run_instr(20'h1A000, 0, 4'b0000);
        run_instr(20'h11901, 1, 4'b1011);
        run_instr(20'h0A000, 0, 4'b0000);
        run_instr(20'hE082F, 0, 4'b0000);
        run_instr(20'hEC000, 0, 4'b0000);
        run_instr(20'hE0500, 1, 4'b0100);

        // Abort an LDR in MEMREAD
        @(negedge clock);
        check_cycle("abort fetch", ST_FETCH, exp_obs(ST_FETCH, cur_ins, 1'b0));
        @(posedge clock); #1;
        cur_ins = 20'hE5921;
        bus.instruction = cur_ins;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check_cycle("abort memread", ST_MEMREAD, exp_obs(ST_MEMREAD, cur_ins, 1'b1));
        #1;
        reset = 1'b0;
        #1;
        e = exp_obs(ST_FETCH, cur_ins, 1'b0);
        e.irw = 0;
        e.pcw = 0;
        check_cycle("abort in reset", ST_FETCH, e);
        @(posedge clock); #1;
        reset = 1'b1;
        mflags = '0;
        run_instr(20'h0A000, 0, 4'b0000);
        run_instr(20'h1A000, 0, 4'b0000);

        for (int i = 0; i < 400; i++) begin
            run_instr(20'($urandom), 0, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
